// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC sequencing, single-outstanding imem handshake, IF/ID outputs.
// Optional IF_ALIGN_CHECK_EN adds if_excp_adel and suppresses misaligned fetches.

`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        if_excp_adel
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, r_addr, r_br_tgt;
    logic [31:0] r_hold_pc, r_hold_inst;
    logic [31:0] r_if_pc, r_if_inst;
    logic        r_pend_br, r_drop, r_hold_vld;

    logic        w_run, w_br_now, w_halted;
    logic        w_launch, w_deliver, w_advance, w_capture, w_drop_nx, w_stallreq;
    logic [31:0] w_launch_pc, w_adv_pc, w_dlv_pc, w_dlv_inst;
    logic        w_unused;

    assign w_run    = (stall[0] == `NoStop);
    assign w_br_now = branch_flag && w_run && !flush;
    // A branch resolving on the same cycle the delay slot lands takes effect immediately.
    assign w_adv_pc = w_br_now  ? branch_target :
                      r_pend_br ? r_br_tgt      : r_pc + 32'(PC_STEP);

`ifdef IF_ALIGN_CHECK_EN
    logic r_halt, r_adel, w_adel;
    assign w_halted     = r_halt;
    assign if_excp_adel = r_adel;
    assign imem_addr    = r_addr;
    assign w_unused     = ^stall[5:1];
`else
    assign w_halted  = 1'b0;
    assign imem_addr = {r_addr[31:2], 2'b00};
    assign w_unused  = ^{stall[5:1], r_addr[1:0]};
`endif

    assign imem_req    = (r_state == REQ);
    assign stallreq_if = w_stallreq;
    assign if_pc       = r_if_pc;
    assign if_inst     = r_if_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_launch    = 1'b0;
        w_launch_pc = r_pc;
        w_deliver   = 1'b0;
        w_dlv_pc    = r_pc;
        w_dlv_inst  = imem_rdata;
        w_advance   = 1'b0;
        w_capture   = 1'b0;
        w_drop_nx   = r_drop;
        w_stallreq  = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        w_adel      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_launch    = 1'b1;
                    w_launch_pc = new_pc;
                end else if (!w_halted) begin
                    w_launch = 1'b1;
                end
            end
            REQ: begin
                // The request is never withdrawn; a flush only poisons its response.
                w_stallreq = 1'b1;
                if (imem_gnt) begin
                    w_state_nx = WAIT;
                    w_drop_nx  = r_drop || flush;
                end else if (flush) begin
                    w_drop_nx = 1'b1;
                end
            end
            WAIT: begin
                w_stallreq = 1'b1;
                if (imem_rvalid) begin
                    if (flush || r_drop) begin
                        w_drop_nx   = 1'b0;
                        w_launch    = 1'b1;
                        w_launch_pc = flush ? new_pc : r_pc;
                    end else if (w_run) begin
                        w_deliver   = 1'b1;
                        w_advance   = 1'b1;
                        w_launch    = 1'b1;
                        w_launch_pc = w_adv_pc;
                    end else begin
                        w_capture  = 1'b1;
                        w_state_nx = HOLD;
                    end
                end else if (flush) begin
                    w_drop_nx = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_launch    = 1'b1;
                    w_launch_pc = new_pc;
                end else if (w_run) begin
                    w_deliver   = r_hold_vld;
                    w_dlv_pc    = r_hold_pc;
                    w_dlv_inst  = r_hold_inst;
                    w_advance   = 1'b1;
                    w_launch    = 1'b1;
                    w_launch_pc = w_adv_pc;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (w_launch) w_state_nx = REQ;
`ifdef IF_ALIGN_CHECK_EN
        // Misaligned target: issue nothing and park until the handler flushes us away.
        w_adel = w_launch && (w_launch_pc[1:0] != 2'b00);
        if (w_adel) w_state_nx = IDLE;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_br_tgt    <= 32'h0;
            r_pend_br   <= 1'b0;
            r_drop      <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_hold_pc   <= 32'h0;
            r_hold_inst <= 32'h0;
        end else begin
            r_drop <= w_drop_nx;
            if (w_launch) r_addr <= w_launch_pc;

            if (flush)          r_pc <= new_pc;
            else if (w_advance) r_pc <= w_adv_pc;

            if (flush || w_advance) begin
                r_pend_br <= 1'b0;
            end else if (w_br_now) begin
                r_pend_br <= 1'b1;
                r_br_tgt  <= branch_target;
            end

            if (flush) begin
                r_hold_vld  <= 1'b0;
                r_hold_pc   <= 32'h0;
                r_hold_inst <= 32'h0;
            end else if (w_capture) begin
                r_hold_vld  <= 1'b1;
                r_hold_pc   <= r_pc;
                r_hold_inst <= imem_rdata;
            end else if (w_deliver && r_state == HOLD) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_pc   <= 32'h0;
            r_if_inst <= 32'h0;
        end else begin
`ifdef IF_ALIGN_CHECK_EN
            if (w_adel) begin
                r_if_pc   <= w_launch_pc;
                r_if_inst <= 32'h0;
            end else
`endif
            if (flush) begin
                r_if_pc   <= 32'h0;
                r_if_inst <= 32'h0;
            end else if (w_deliver) begin
                r_if_pc   <= w_dlv_pc;
                r_if_inst <= w_dlv_inst;
            end else if (w_run) begin
                r_if_pc   <= 32'h0;
                r_if_inst <= 32'h0;
            end
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt <= 1'b0;
            r_adel <= 1'b0;
        end else begin
            if (w_launch) r_halt <= w_adel;
            if (w_adel)                          r_adel <= 1'b1;
            else if (flush || w_deliver || w_run) r_adel <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed, cycle-exact bench for if_fetch with a small imem responder model.

module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_pc, if_inst;
    logic        stallreq_if;
`ifdef IF_ALIGN_CHECK_EN
    logic        if_excp_adel;
`endif

    int n_cmp = 0;
    int n_err = 0;

    if_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
`ifdef IF_ALIGN_CHECK_EN
        , .if_excp_adel(if_excp_adel)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2401_0001;
            32'h0000_0004: return 32'h2402_0002;
            32'h0000_0010: return 32'h8C03_0010;
            default:       return 32'hC0DE_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    // Responder: rvalid arrives 'lat' cycles after the cycle following a grant.
    int          lat = 0;
    int          m_cnt = 0;
    logic        m_pend = 1'b0;
    logic        m_acc;
    logic [31:0] m_a, m_addr = 32'h0;

    always @(posedge clk) begin
        m_acc = imem_req && imem_gnt;
        m_a   = imem_addr;
        #1;
        if (m_acc) begin
            m_pend = 1'b1;
            m_addr = m_a;
            m_cnt  = lat;
        end
        if (m_pend && m_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_addr);
            m_pend      = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (m_pend) m_cnt--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
        n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_if_pc: got %h exp 0", if_pc); end
        n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL rst_if_inst: got %h exp 0", if_inst); end
        n_cmp++; if (stallreq_if !== 1'b0) begin n_err++; $display("FAIL rst_stallreq: got %b exp 0", stallreq_if); end
        rst = 1'b0;
    endtask

    task automatic test_seq();
        tick();
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL seq_req0: got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL seq_addr0: got %h exp 0", imem_addr); end
        n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL seq_stallreq_req: got %b exp 1", stallreq_if); end
        tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_req_wait: got %b exp 0", imem_req); end
        n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL seq_stallreq_wait: got %b exp 1", stallreq_if); end
        tick();
        n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL seq_pc0: got %h exp 0", if_pc); end
        n_cmp++; if (if_inst !== 32'h2401_0001) begin n_err++; $display("FAIL seq_inst0: got %h exp 24010001", if_inst); end
        n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL seq_addr4: got %h exp 4", imem_addr); end
        tick();
        n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL seq_bubble: got %h exp 0", if_inst); end
        tick();
        n_cmp++; if (if_pc !== 32'h4) begin n_err++; $display("FAIL seq_pc4: got %h exp 4", if_pc); end
        n_cmp++; if (if_inst !== 32'h2402_0002) begin n_err++; $display("FAIL seq_inst4: got %h exp 24020002", if_inst); end
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL seq_addr8: got %h exp 8", imem_addr); end
    endtask

    task automatic test_branch();
        branch_flag = 1'b1; branch_target = 32'h100;
        tick();
        branch_flag = 1'b0;
        tick();
        n_cmp++; if (if_pc !== 32'h8) begin n_err++; $display("FAIL br_slot_pc: got %h exp 8", if_pc); end
        n_cmp++; if (if_inst !== 32'hC0DE_0008) begin n_err++; $display("FAIL br_slot_inst: got %h exp c0de0008", if_inst); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL br_target_addr: got %h exp 100", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL br_req: got %b exp 1", imem_req); end
    endtask

    task automatic test_flush_wait();
        lat = 1; branch_flag = 1'b1; branch_target = 32'h200;
        tick();
        branch_flag = 1'b0; flush = 1'b1; new_pc = 32'h180;
        tick();
        flush = 1'b0;
        n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL fl_discard_stallreq: got %b exp 1", stallreq_if); end
        n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL fl_inst_zero: got %h exp 0", if_inst); end
        tick();
        n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL fl_dropped: got %h exp 0", if_inst); end
        n_cmp++; if (imem_addr !== 32'h180) begin n_err++; $display("FAIL fl_addr: got %h exp 180", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL fl_req: got %b exp 1", imem_req); end
        tick(); tick(); tick();
        n_cmp++; if (if_pc !== 32'h180) begin n_err++; $display("FAIL fl_pc: got %h exp 180", if_pc); end
        n_cmp++; if (if_inst !== 32'hC0DE_0180) begin n_err++; $display("FAIL fl_inst: got %h exp c0de0180", if_inst); end
        n_cmp++; if (imem_addr !== 32'h184) begin n_err++; $display("FAIL fl_pend_br_cleared: got %h exp 184", imem_addr); end
        lat = 0;
    endtask

    task automatic test_stall();
        flush = 1'b1; new_pc = 32'hC;
        tick();
        flush = 1'b0;
        tick();
        n_cmp++; if (imem_addr !== 32'hC) begin n_err++; $display("FAIL st_addr_c: got %h exp c", imem_addr); end
        tick(); tick();
        n_cmp++; if (if_inst !== 32'hC0DE_000C) begin n_err++; $display("FAIL st_inst_c: got %h exp c0de000c", if_inst); end
        n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL st_addr_10: got %h exp 10", imem_addr); end
        stall = 6'b000001;
        tick();
        n_cmp++; if (if_inst !== 32'hC0DE_000C) begin n_err++; $display("FAIL st_hold1: got %h exp c0de000c", if_inst); end
        n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL st_stallreq_wait: got %b exp 1", stallreq_if); end
        tick();
        n_cmp++; if (stallreq_if !== 1'b0) begin n_err++; $display("FAIL st_stallreq_hold: got %b exp 0", stallreq_if); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st_req_hold: got %b exp 0", imem_req); end
        n_cmp++; if (if_pc !== 32'hC) begin n_err++; $display("FAIL st_hold_pc: got %h exp c", if_pc); end
        tick();
        n_cmp++; if (if_inst !== 32'hC0DE_000C) begin n_err++; $display("FAIL st_hold2: got %h exp c0de000c", if_inst); end
        tick();
        n_cmp++; if (if_pc !== 32'hC) begin n_err++; $display("FAIL st_hold3_pc: got %h exp c", if_pc); end
        n_cmp++; if (if_inst !== 32'hC0DE_000C) begin n_err++; $display("FAIL st_hold3: got %h exp c0de000c", if_inst); end
        stall = 6'b0;
        tick();
        n_cmp++; if (if_pc !== 32'h10) begin n_err++; $display("FAIL st_rel_pc: got %h exp 10", if_pc); end
        n_cmp++; if (if_inst !== 32'h8C03_0010) begin n_err++; $display("FAIL st_rel_inst: got %h exp 8c030010", if_inst); end
        n_cmp++; if (imem_addr !== 32'h14) begin n_err++; $display("FAIL st_rel_addr: got %h exp 14", imem_addr); end
    endtask

    task automatic test_gnt_low();
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL gl_req[%0d]: got %b exp 1", i, imem_req); end
            n_cmp++; if (imem_addr !== 32'h14) begin n_err++; $display("FAIL gl_addr[%0d]: got %h exp 14", i, imem_addr); end
            flush  = (i == 2);
            new_pc = 32'h40;
            tick();
        end
        n_cmp++; if (imem_addr !== 32'h14) begin n_err++; $display("FAIL gl_addr_end: got %h exp 14", imem_addr); end
        imem_gnt = 1'b1;
        tick(); tick();
        n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL gl_dropped: got %h exp 0", if_inst); end
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL gl_newaddr: got %h exp 40", imem_addr); end
        tick(); tick();
        n_cmp++; if (if_pc !== 32'h40) begin n_err++; $display("FAIL gl_pc: got %h exp 40", if_pc); end
        n_cmp++; if (if_inst !== 32'hC0DE_0040) begin n_err++; $display("FAIL gl_inst: got %h exp c0de0040", if_inst); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        tick();
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr: got %h exp fffffffc", imem_addr); end
        tick(); tick();
        n_cmp++; if (if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_pc: got %h exp fffffffc", if_pc); end
        n_cmp++; if (if_inst !== 32'hC0DE_FFFC) begin n_err++; $display("FAIL wr_inst: got %h exp c0defffc", if_inst); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wr_next: got %h exp 0", imem_addr); end
    endtask

    task automatic test_flush_branch();
        flush = 1'b1; new_pc = 32'h200; branch_flag = 1'b1; branch_target = 32'h300;
        tick();
        flush = 1'b0; branch_flag = 1'b0;
        tick();
        n_cmp++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL fb_addr: got %h exp 200", imem_addr); end
        tick(); tick();
        n_cmp++; if (if_pc !== 32'h200) begin n_err++; $display("FAIL fb_pc: got %h exp 200", if_pc); end
        n_cmp++; if (imem_addr !== 32'h204) begin n_err++; $display("FAIL fb_br_lost: got %h exp 204", imem_addr); end
    endtask

    task automatic test_branch_stall();
        stall = 6'b000001; branch_flag = 1'b1; branch_target = 32'h400;
        tick();
        stall = 6'b0; branch_flag = 1'b0;
        n_cmp++; if (if_pc !== 32'h200) begin n_err++; $display("FAIL bs_hold_pc: got %h exp 200", if_pc); end
        tick();
        n_cmp++; if (if_pc !== 32'h204) begin n_err++; $display("FAIL bs_pc: got %h exp 204", if_pc); end
        n_cmp++; if (if_inst !== 32'hC0DE_0204) begin n_err++; $display("FAIL bs_inst: got %h exp c0de0204", if_inst); end
        n_cmp++; if (imem_addr !== 32'h208) begin n_err++; $display("FAIL bs_ignored: got %h exp 208", imem_addr); end
    endtask

    task automatic test_align();
        flush = 1'b1; new_pc = 32'h102;
        tick();
        flush = 1'b0;
        tick();
`ifdef IF_ALIGN_CHECK_EN
        n_cmp++; if (if_excp_adel !== 1'b1) begin n_err++; $display("FAIL al_adel: got %b exp 1", if_excp_adel); end
        n_cmp++; if (if_pc !== 32'h102) begin n_err++; $display("FAIL al_pc: got %h exp 102", if_pc); end
        n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL al_inst: got %h exp 0", if_inst); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL al_noreq: got %b exp 0", imem_req); end
        tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL al_parked: got %b exp 0", imem_req); end
`else
        n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL al_forced: got %h exp 100", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL al_req: got %b exp 1", imem_req); end
`endif
    endtask

    task automatic test_reset_mid();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rm_req: got %b exp 0", imem_req); end
        n_cmp++; if (stallreq_if !== 1'b0) begin n_err++; $display("FAIL rm_stallreq: got %b exp 0", stallreq_if); end
        n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rm_pc: got %h exp 0", if_pc); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_addr: got %h exp 0", imem_addr); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rm_refetch_req: got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_refetch_addr: got %h exp 0", imem_addr); end
        tick(); tick();
        n_cmp++; if (if_inst !== 32'h2401_0001) begin n_err++; $display("FAIL rm_inst: got %h exp 24010001", if_inst); end
    endtask

    initial begin
        tick(); tick();
        test_reset();
        test_seq();
        test_branch();
        test_flush_wait();
        test_stall();
        test_gnt_low();
        test_wrap();
        test_flush_branch();
        test_branch_stall();
        test_align();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
